wiphase_top_level_button_pio: RTL and testbench

WIPHASE_TOP_LEVEL_BUTTON_PIO -- requirements
Module: wiphase_top_level_button_pio

---
 rtl/wiphase_top_level_button_pio.sv | 91 +++++++++
 tb/tb_wiphase_top_level_button_pio.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wiphase_top_level_button_pio.sv
// Push-button PIO slave: synchronised inputs, falling-edge capture, masked level interrupt.
// Latency: in_port -> data register 2 clocks, -> edge_capture 3 clocks; readdata is combinational (0 wait states).
// Backpressure: none; Avalon-MM slave accepts every access in the cycle it is presented.
//
// Ports:
//   clk, reset_n                : system clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata, readdata: Avalon-MM slave (0 data, 1 reserved, 2 irq_mask, 3 edge_capture)
//   in_port                     : asynchronous button inputs, idle high
//   irq                         : level interrupt = |(edge_capture & irq_mask)
//
// Build option: define BUTTON_PIO_BIT_CLEAR_EN so a write to edge_capture clears only the
// bits written as 1; otherwise any write to edge_capture clears every bit.

module wiphase_top_level_button_pio #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;

    assign wr_en    = chipselect & ~write_n;
    assign edge_det = prev & ~sync2;

`ifdef BUTTON_PIO_BIT_CLEAR_EN
    assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
`else
    assign clr_bits = (wr_en && address == 2'd3) ? '1 : '0;
`endif

    // Sync chain resets to ones: buttons idle high, so release never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Clear is applied first and the new edge ORed in afterwards, so a press
    // arriving in the same cycle as a clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr_bits) | edge_det;
        end
    end

    // Read mux is not gated by chipselect; the bus ignores readdata outside reads.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = sync2;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_wiphase_top_level_button_pio.sv
module tb_wiphase_top_level_button_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    wiphase_top_level_button_pio #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(2);
        check("irq_in_reset", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Reset state of the register map
        rd(2'd0, 32'h0000000F, "rst_data");
        rd(2'd1, 32'h0, "rst_reserved");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_capture");
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Press bit 0 just after a clock edge; the next edge is k
        tick(1);
        in_port = 4'hE;
        tick(1);                                  // edge k
        rd(2'd0, 32'hF, "lat_data_k");
        tick(1);                                  // edge k+1
        rd(2'd0, 32'hE, "lat_data_k1");
        rd(2'd3, 32'h0, "lat_cap_k1");
        tick(1);                                  // edge k+2
        rd(2'd3, 32'h1, "lat_cap_k2");
        check("irq_masked", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h1);
        check("irq_unmask", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'h1, "mask_rb");

        // Clear, then release: rising edges must not capture
        wr(2'd3, 32'hF);
        rd(2'd3, 32'h0, "clr_all");
        in_port = 4'hF;
        tick(4);
        rd(2'd3, 32'h0, "rise_no_cap");

        // Capture 0x5 with mask 0xF, then clear-write data 0x1
        in_port = 4'hA;
        tick(3);
        rd(2'd3, 32'h5, "cap_5");
        wr(2'd2, 32'hF);
        check("irq_cap5", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h1);
`ifdef BUTTON_PIO_BIT_CLEAR_EN
        rd(2'd3, 32'h4, "partial_clr");
        check("irq_after_clr", {31'd0, irq}, 32'd1);
`else
        rd(2'd3, 32'h0, "full_clr");
        check("irq_after_clr", {31'd0, irq}, 32'd0);
`endif

        // Edge on bit 1 arrives in the same cycle as a clear-write of 0x2
        in_port = 4'hF;
        tick(3);
        wr(2'd3, 32'hF);
        rd(2'd3, 32'h0, "pre_race_clr");
        in_port = 4'hD;
        tick(2);                                  // edges k, k+1; detect live now
        wr(2'd3, 32'h2);                          // edge k+2: set and clear together
        rd(2'd3, 32'h2, "set_wins");

        // Full toggle F->0->F, then writes to RO/reserved addresses
        in_port = 4'hF;
        tick(3);
        wr(2'd3, 32'hF);
        in_port = 4'h0;
        tick(3);
        rd(2'd3, 32'hF, "toggle_fall");
        in_port = 4'hF;
        tick(3);
        rd(2'd3, 32'hF, "toggle_rise");
        wr(2'd0, 32'hFFFFFFFF);
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd1, 32'h0, "ro_reserved");
        rd(2'd2, 32'hF, "ro_mask");
        rd(2'd3, 32'hF, "ro_capture");
        rd(2'd0, 32'hF, "ro_data");

        // Mid-operation reset with in_port held low
        in_port = 4'h0;
        tick(3);
        check("irq_pre_reset", {31'd0, irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("irq_async_rst", {31'd0, irq}, 32'd0);
        rd(2'd3, 32'h0, "rst_cap_clear");
        rd(2'd2, 32'h0, "rst_mask_clear");
        tick(2);
        reset_n = 1'b1;
        tick(1);
        rd(2'd3, 32'h0, "post_rst_clk1");
        tick(2);
        rd(2'd3, 32'hF, "post_rst_cap");
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
